// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, types and codeword helper for the K=3 rate-1/2 Viterbi receiver
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 4;
  localparam int NUM_SLOTS  = 8;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] metric_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } fsm_t;

  // Slot is {s1, s0, b}; the encoder register seen by the generators is {b, s1, s0}.
  function automatic logic [1:0] exp_code(input logic [2:0] slot);
    logic [2:0] taps;
    taps = {slot[0], slot[2], slot[1]};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/bmc_fifo.sv
// rtl/bmc_fifo.sv - synchronous symbol FIFO with registered full/empty flags
module bmc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // A write into an empty FIFO becomes readable one cycle after it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0) || (count == '0);
    end
  end

endmodule

// File: rtl/bmc_sequencer.sv
// rtl/bmc_sequencer.sv - time-shared branch-metric sequencer feeding the ACS array
// Optional erasure masking is enabled by defining VITERBI_ERASURE_EN.
module bmc_sequencer
  import viterbi_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_pair,
`ifdef VITERBI_ERASURE_EN
  input  logic [1:0]                   in_erase,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output metric_t                      out_metric,
  output logic [1:0]                   out_state,
  output logic                         out_bit,
  output logic                         out_last,
  output logic [$clog2(FRAME_LEN)-1:0] out_step,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int SW = $clog2(FRAME_LEN);
`ifdef VITERBI_ERASURE_EN
  localparam int EW = 4;
`else
  localparam int EW = 2;
`endif
  localparam logic [2:0]    LAST_SLOT = 3'(NUM_SLOTS - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(FRAME_LEN - 1);

  fsm_t          state;
  logic [2:0]    slot;
  logic [SW-1:0] step;
  logic [EW-1:0] work;
  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          last_slot;
  logic          last_step;
  logic [1:0]    diff;

`ifdef VITERBI_ERASURE_EN
  assign fifo_wdata = {in_erase, in_pair};
  assign diff       = (work[1:0] ^ exp_code(slot)) & ~work[3:2];
`else
  assign fifo_wdata = in_pair;
  assign diff       = work ^ exp_code(slot);
`endif

  assign last_slot  = (slot == LAST_SLOT);
  assign last_step  = (step == LAST_STEP);
  assign in_ready   = !fifo_full;
  assign out_metric = {diff[1] & diff[0], diff[1] ^ diff[0]};
  assign out_state  = slot[2:1];
  assign out_bit    = slot[0];
  assign out_last   = out_valid && last_slot;
  assign out_step   = step;

  // Back-to-back symbols inside a frame are popped on the slot-7 handshake.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) ||
                     (state == ISSUE && out_ready && last_slot && !last_step));

  bmc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      step       <= '0;
      work       <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            work      <= fifo_rdata;
            slot      <= '0;
            state     <= ISSUE;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            if (!last_slot) begin
              slot <= slot + 3'd1;
            end else if (last_step) begin
              slot       <= '0;
              state      <= DONE;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              step <= step + SW'(1);
              slot <= '0;
              if (!fifo_empty) begin
                work <= fifo_rdata;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          step  <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_sequencer.sv
// tb/tb_bmc_sequencer.sv - directed table-driven bench for bmc_sequencer
module tb_bmc_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_pair;
`ifdef VITERBI_ERASURE_EN
  logic [1:0] in_erase;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_metric;
  logic [1:0] out_state;
  logic       out_bit;
  logic       out_last;
  logic [3:0] out_step;
  logic       frame_done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  pair;
    logic [1:0]  erase;
    logic [15:0] metrics;
  } vec_t;

  vec_t vecs[$];

  bmc_sequencer #(
    .DEPTH     (4),
    .FRAME_LEN (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pair    (in_pair),
`ifdef VITERBI_ERASURE_EN
    .in_erase   (in_erase),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_metric (out_metric),
    .out_state  (out_state),
    .out_bit    (out_bit),
    .out_last   (out_last),
    .out_step   (out_step),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] p, input logic [1:0] e,
                               input int m0, input int m1, input int m2, input int m3,
                               input int m4, input int m5, input int m6, input int m7);
    vec_t v;
    v.pair    = p;
    v.erase   = e;
    v.metrics = {2'(m7), 2'(m6), 2'(m5), 2'(m4), 2'(m3), 2'(m2), 2'(m1), 2'(m0)};
    return v;
  endfunction

  task automatic drive_pair(input logic [1:0] p, input logic [1:0] e);
    in_pair = p;
`ifdef VITERBI_ERASURE_EN
    in_erase = e;
`else
    if (e != 2'b00) $display("note: erase pattern ignored in this build");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One symbol pushed into an idle, empty sequencer with out_ready held high.
  task automatic run_vec(input vec_t v, input int step_exp, input string tag);
    logic [15:0] m;
    m = v.metrics;
    @(negedge clk);
    in_valid = 1'b1;
    drive_pair(v.pair, v.erase);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " valid_after_push"}, out_valid, 0);
    @(negedge clk);
    check({tag, " valid_push_plus1"}, out_valid, 0);
    @(negedge clk);
    check({tag, " valid_push_plus2"}, out_valid, 1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s metric slot%0d", tag, k), out_metric, m[2*k +: 2]);
      check($sformatf("%s state slot%0d", tag, k), out_state, k >> 1);
      check($sformatf("%s bit slot%0d", tag, k), out_bit, k & 1);
      check($sformatf("%s last slot%0d", tag, k), out_last, (k == 7) ? 1 : 0);
      check($sformatf("%s step slot%0d", tag, k), out_step, step_exp);
      @(negedge clk);
    end
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " busy_drop"}, busy, 0);
  endtask

  initial begin
    int nvalid, first_cyc, last_cyc, ndone, done_cyc, step_after, step_err, met_err, pushed;
    int hs, sym, sl;
    logic prev_stall, hit, got_full;
    logic [1:0] h_metric, h_state;
    logic h_bit, h_last;
    logic [1:0] fill[5];
    logic [15:0] m11;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive_pair(2'b00, 2'b00);

    vecs.push_back(mkv(2'b00, 2'b00, 0, 2, 2, 0, 1, 1, 1, 1));
    vecs.push_back(mkv(2'b11, 2'b00, 2, 0, 0, 2, 1, 1, 1, 1));
    vecs.push_back(mkv(2'b10, 2'b00, 1, 1, 1, 1, 0, 2, 2, 0));
    vecs.push_back(mkv(2'b01, 2'b00, 1, 1, 1, 1, 2, 0, 0, 2));
`ifdef VITERBI_ERASURE_EN
    vecs.push_back(mkv(2'b11, 2'b01, 1, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mkv(2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_metric", out_metric, 0);
    check("rst out_state", out_state, 0);
    check("rst out_bit", out_bit, 0);
    check("rst out_last", out_last, 0);
    check("rst out_step", out_step, 0);
    check("rst frame_done", frame_done, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 1);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i, $sformatf("vec%0d", i));

    // Full frame streamed back to back.
    do_reset();
    nvalid = 0; first_cyc = -1; last_cyc = -1; ndone = 0; done_cyc = -1;
    step_after = -1; step_err = 0; met_err = 0; pushed = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (in_valid) pushed++;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        sym = nvalid / 8;
        sl  = nvalid % 8;
        if (int'(out_step) != sym) step_err++;
        m11 = vecs[sym % 4].metrics;
        if (out_metric !== m11[2*sl +: 2]) met_err++;
        nvalid++;
      end
      if (frame_done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        step_after = int'(out_step);
        in_valid = 1'b0;
        break;
      end
      in_valid = (pushed < 16) && in_ready;
      drive_pair(vecs[pushed % 4].pair, 2'b00);
    end
    in_valid = 1'b0;
    check("frame valid_count", nvalid, 128);
    check("frame contiguous", last_cyc - first_cyc, 127);
    check("frame done_count", ndone, 1);
    check("frame done_after_last", done_cyc, last_cyc + 1);
    check("frame step_after_done", step_after, 0);
    check("frame step_errors", step_err, 0);
    check("frame metric_errors", met_err, 0);

    // Stall with alternating out_ready while the FIFO is filled.
    out_ready = 1'b0;
    fill[0] = 2'b11; fill[1] = 2'b00; fill[2] = 2'b10; fill[3] = 2'b01; fill[4] = 2'b11;
    pushed = 0;
    for (int cyc = 0; cyc < 40 && pushed < 5; cyc++) begin
      @(negedge clk);
      if (in_valid) pushed++;
      in_valid = (pushed < 5) && in_ready;
      drive_pair(fill[pushed % 5], 2'b00);
    end
    in_valid = 1'b0;
    check("fill pushes", pushed, 5);
    check("full in_ready", in_ready, 0);
    check("full out_valid", out_valid, 1);
    m11 = vecs[1].metrics;
    hs = 0; prev_stall = 1'b0; got_full = 1'b0;
    h_metric = '0; h_state = '0; h_bit = 1'b0; h_last = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (hs == 8) break;
      @(negedge clk);
      if (prev_stall) begin
        check("stall hold metric", out_metric, h_metric);
        check("stall hold state", out_state, h_state);
        check("stall hold bit", out_bit, h_bit);
        check("stall hold last", out_last, h_last);
      end
      out_ready = ~out_ready;
      if (out_valid && out_ready) begin
        check($sformatf("stall metric hs%0d", hs), out_metric, m11[2*hs +: 2]);
        check($sformatf("stall state hs%0d", hs), out_state, hs >> 1);
        if (hs == 7) check("still full before pop", in_ready, 0);
        hs++;
      end
      prev_stall = out_valid && !out_ready;
      h_metric = out_metric; h_state = out_state; h_bit = out_bit; h_last = out_last;
    end
    check("stall handshakes", hs, 8);
    @(negedge clk);
    check("pop restores in_ready", in_ready, 1);
    check("next symbol no bubble", out_valid, 1);
    check("next symbol slot0", {out_state, out_bit}, 0);
    check("next symbol metric", out_metric, 0);

    // Reset in the middle of a frame.
    out_ready = 1'b1;
    do_reset();
    pushed = 0; hit = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (in_valid) pushed++;
      if (out_valid && out_step == 4'd5 && out_state == 2'd1 && out_bit == 1'b1) begin
        hit = 1'b1;
        rst = 1'b1;
        in_valid = 1'b0;
        break;
      end
      in_valid = in_ready;
      drive_pair(vecs[pushed % 4].pair, 2'b00);
    end
    check("reached step5 slot3", hit, 1);
    @(negedge clk);
    rst = 1'b0;
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst out_step", out_step, 0);
    check("midrst frame_done", frame_done, 0);
    run_vec(vecs[2], 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
